twiddle_table_loader: RTL and testbench
=======================================

Name: twiddle_table_loader

Overview:
- Runtime-writable twiddle table for the 32-point MDC FFT. It is the writer side of the twiddle coefficient path.
- Accepts (real, imag) coefficient pairs serially over a valid/ready port and packs them into 8 rows of 4 lanes.
- Replays the rows with the same START/STAGE/count sequencing the butterfly stages expect from the fixed twiddle ROM.
- Allows coefficient sets (e.g. conjugated for IFFT, or rescaled) to be swapped without resynthesis.

Parameters:
NB, 9, coefficient word width (same custom float format as the FFT datapath)
N, 32, table depth in coefficient pairs
LANES, 4, coefficients per output row (N/LANES = 8 rows)

Ports:
CLK  input  1  clock
RST  input  1  asynchronous active-low reset
CLR  input  1  sync pulse; restart table load from entry 0, clear LOAD_ERR
LOAD_VALID  input  1  LOAD_WR/LOAD_WI hold a coefficient pair
LOAD_READY  output  1  high while the block accepts pairs
LOAD_WR  input  NB  real part of the incoming coefficient
LOAD_WI  input  NB  imaginary part of the incoming coefficient
TABLE_VALID  output  1  all N entries written; readout enabled
LOAD_ERR  output  1  sticky; a pair was offered while the table was full
START  input  1  sync; readout counter restarts at row 0
STAGE  input  1  0 = full-table sweep, 1 = alternating rows 0/4
OR  output  NB*LANES  real parts of the current row, lane 0 in bits [NB-1:0]
OI  output  NB*LANES  imaginary parts, same packing

Behaviour:
- Reset (RST low, asynchronous):
  - All storage entries become 0; write index = 0; count = 0; state = LOADING.
  - Outputs: TABLE_VALID = 0, LOAD_ERR = 0, LOAD_READY = 1, OR = 0, OI = 0.
- The FSM has two states, LOADING and ARMED.
  - LOADING: LOAD_READY = 1. A transfer occurs on a rising edge with LOAD_VALID & LOAD_READY & ~CLR.
    - Entry at write index k is stored at row k/4, lane k%4; the index then increments.
    - The transfer at index 31 moves the FSM to ARMED. On the next cycle TABLE_VALID = 1 and LOAD_READY = 0. The index wraps to 0.
  - ARMED: LOAD_READY = 0, and storage is frozen.
    - LOAD_VALID high in ARMED sets LOAD_ERR (sticky) and the data is discarded.
- CLR is synchronous and has the highest priority after reset.
  - Next state = LOADING, index = 0, TABLE_VALID = 0, LOAD_ERR = 0.
  - Storage contents are retained but are not visible until a new full load completes.
  - If LOAD_VALID is high in the same cycle as CLR, that write is dropped.
  - CLR in mid-load discards the partial load; the entries already written stay in storage.
- Readout counter: 3-bit count, independent of the FSM.
  - START high: count <= 0; otherwise count <= count + 1, wrapping 7 -> 0. START takes priority.
- Row select (combinational from count, STAGE and storage; zero latency from count):
  - STAGE = 0: row = count (0..7).
  - STAGE = 1: row = 0 when count is even, row = 4 when count is odd.
  - OR = {lane3, lane2, lane1, lane0} real parts of the selected row; OI is the same for the imaginary parts.
  - OR and OI are forced to 0 whenever TABLE_VALID = 0.
- Simultaneous events:
  - The final (index 31) write and START in the same cycle: both take effect.
  - TABLE_VALID rises one cycle after the final write; OR/OI show the table from that cycle on, for the current count.
- Storage holds 2*N*NB bits in registers. There is no read-during-write hazard, because readout is gated by TABLE_VALID and writes only occur while it is 0.

Test Plan:
- Reset then load 32 pairs with LOAD_VALID held high, wr = k, wi = 31-k -> LOAD_READY falls and TABLE_VALID rises the cycle after the 32nd transfer. Then pulse START with STAGE = 0: cycles 0..7 give OR = {4r+3, 4r+2, 4r+1, 4r} for r = 0..7, and the table repeats from cycle 8.
- Same table with STAGE = 1 after START -> OR alternates {3,2,1,0} and {19,18,17,16} every cycle for 16 cycles.
- Load with LOAD_VALID toggling 1,0,1,0 -> exactly 32 accepted transfers, and the contents match the streamed order with no skipped or duplicated entries.
- With the table ARMED, hold LOAD_VALID = 1 for 3 cycles -> LOAD_ERR = 1 and stays high, OR/OI are unchanged. Then CLR -> LOAD_ERR = 0, TABLE_VALID = 0, OR = OI = 0, LOAD_READY = 1.
- Mid-load: after 10 transfers assert CLR together with LOAD_VALID -> that pair is dropped and the index returns to 0. Reloading 32 new pairs makes only the new values visible. Separately, asserting RST low mid-load immediately zeroes all outputs, and the re-read table is all 0 until a new load completes.
- Assert START mid-sweep at count 5 -> count is 0 on the next cycle and OR shows row 0 (STAGE = 0).

Source files
------------

// File: rtl/twiddle_table_loader.sv
// ---------------------------------------------------------------------------
// twiddle_table_loader
//
// Runtime-writable twiddle table for the 32-point MDC FFT. Coefficient
// pairs (real, imag) arrive serially over a valid/ready port and are packed
// into ROWS rows of LANES lanes. Once all N pairs are written, the table is
// armed and replayed row by row with the same START/STAGE/count sequencing
// the butterfly stages use with the fixed twiddle ROM. This lets coefficient
// sets (conjugated for IFFT, rescaled, ...) be swapped without resynthesis.
//
// Ports
//   CLK         clock
//   RST         asynchronous active-low reset
//   CLR         sync pulse: restart load at entry 0, clear LOAD_ERR
//   LOAD_VALID  LOAD_WR/LOAD_WI hold a coefficient pair
//   LOAD_READY  high while pairs are accepted (LOADING state)
//   LOAD_WR     real part of incoming coefficient (NB bits)
//   LOAD_WI     imaginary part of incoming coefficient (NB bits)
//   TABLE_VALID all N entries written; readout enabled
//   LOAD_ERR    sticky: a pair was offered while the table was full
//   START       sync: readout counter restarts at row 0
//   STAGE       0 = full-table sweep, 1 = alternate rows 0 and ROWS/2
//   OR          real parts of current row, lane 0 in bits [NB-1:0]
//   OI          imaginary parts of current row, same packing
// ---------------------------------------------------------------------------
module twiddle_table_loader #(
    parameter int NB    = 9,
    parameter int N     = 32,
    parameter int LANES = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                CLR,
    input  logic                LOAD_VALID,
    output logic                LOAD_READY,
    input  logic [NB-1:0]       LOAD_WR,
    input  logic [NB-1:0]       LOAD_WI,
    output logic                TABLE_VALID,
    output logic                LOAD_ERR,
    input  logic                START,
    input  logic                STAGE,
    output logic [NB*LANES-1:0] OR,
    output logic [NB*LANES-1:0] OI
);

    // N and LANES are powers of two, so an entry index is simply
    // {row, lane}: entry k lives at row k/LANES, lane k%LANES.
    localparam int ROWS = N / LANES;
    localparam int IW   = $clog2(N);
    localparam int CW   = $clog2(ROWS);
    localparam int LW   = $clog2(LANES);

    typedef enum logic {
        S_LOADING = 1'b0,
        S_ARMED   = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_idx;
    logic [CW-1:0]   r_cnt;
    logic            r_err;
    logic [NB-1:0]   r_wr [N];
    logic [NB-1:0]   r_wi [N];

    logic            w_xfer;
    logic            w_last;
    logic            w_ready;
    logic            w_err_set;
    logic [CW-1:0]   w_row;

    // CLR blocks the transfer in its own cycle, so a pair offered alongside
    // CLR is dropped rather than written at the old index.
    assign w_xfer = LOAD_VALID & (r_state == S_LOADING) & ~CLR;
    assign w_last = w_xfer & (r_idx == IW'(N - 1));

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_LOADING;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state and decoded controls
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            S_LOADING: begin
                w_ready = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                // Table is full: any offered pair is discarded and flagged.
                w_err_set = LOAD_VALID;
            end
            default: begin
                w_state_nxt = S_LOADING;
            end
        endcase
        if (CLR) begin
            w_state_nxt = S_LOADING;
            w_err_set   = 1'b0;
        end
    end

    assign LOAD_READY  = w_ready;
    assign TABLE_VALID = (r_state == S_ARMED);
    assign LOAD_ERR    = r_err;

    // ---------------------------------------------------------------------
    // Write index and sticky error
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_idx <= '0;
            r_err <= 1'b0;
        end else begin
            if (CLR) begin
                r_idx <= '0;
            end else if (w_xfer) begin
                r_idx <= w_last ? '0 : r_idx + IW'(1);
            end

            if (CLR) begin
                r_err <= 1'b0;
            end else if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Coefficient storage. CLR leaves contents in place; they stay hidden
    // behind TABLE_VALID until a fresh full load completes.
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int k = 0; k < N; k++) begin
                r_wr[k] <= '0;
                r_wi[k] <= '0;
            end
        end else if (w_xfer) begin
            r_wr[r_idx] <= LOAD_WR;
            r_wi[r_idx] <= LOAD_WI;
        end
    end

    // ---------------------------------------------------------------------
    // Readout counter: free-running, independent of the load FSM.
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt <= '0;
        end else if (START) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // STAGE=1 ping-pongs between row 0 and the middle row on count parity.
    assign w_row = STAGE ? (r_cnt[0] ? CW'(ROWS / 2) : '0) : r_cnt;

    // ---------------------------------------------------------------------
    // Per-lane row mux, gated by TABLE_VALID.
    // ---------------------------------------------------------------------
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        localparam logic [LW-1:0] LIDX = LW'(l);
        logic [IW-1:0] w_rd_idx;
        assign w_rd_idx         = {w_row, LIDX};
        assign OR[l*NB +: NB]   = TABLE_VALID ? r_wr[w_rd_idx] : '0;
        assign OI[l*NB +: NB]   = TABLE_VALID ? r_wi[w_rd_idx] : '0;
    end

endmodule

// File: tb/tb_twiddle_table_loader.sv
module tb_twiddle_table_loader;

    localparam int NB    = 9;
    localparam int N     = 32;
    localparam int LANES = 4;
    localparam int ROWS  = N / LANES;

    logic                CLK = 1'b0;
    logic                RST;
    logic                CLR;
    logic                LOAD_VALID;
    logic [NB-1:0]       LOAD_WR;
    logic [NB-1:0]       LOAD_WI;
    logic                START;
    logic                STAGE;
    logic                LOAD_READY;
    logic                TABLE_VALID;
    logic                LOAD_ERR;
    logic [NB*LANES-1:0] dut_or;
    logic [NB*LANES-1:0] dut_oi;

    twiddle_table_loader #(.NB(NB), .N(N), .LANES(LANES)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .CLR        (CLR),
        .LOAD_VALID (LOAD_VALID),
        .LOAD_READY (LOAD_READY),
        .LOAD_WR    (LOAD_WR),
        .LOAD_WI    (LOAD_WI),
        .TABLE_VALID(TABLE_VALID),
        .LOAD_ERR   (LOAD_ERR),
        .START      (START),
        .STAGE      (STAGE),
        .OR         (dut_or),
        .OI         (dut_oi)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic                rdy;
        logic                tv;
        logic                err;
        logic [NB*LANES-1:0] r;
        logic [NB*LANES-1:0] i;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    // Reference model: flat coefficient list plus load/readout bookkeeping.
    logic [NB-1:0] m_r [N];
    logic [NB-1:0] m_i [N];
    int            m_n;
    bit            m_armed;
    bit            m_err;
    int            m_cnt;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        int   row;
        e.rdy = !m_armed;
        e.tv  = m_armed;
        e.err = m_err;
        e.r   = '0;
        e.i   = '0;
        if (m_armed) begin
            if (STAGE) row = (m_cnt % 2 == 1) ? ROWS / 2 : 0;
            else       row = m_cnt;
            for (int l = 0; l < LANES; l++) begin
                e.r[l*NB +: NB] = m_r[row*LANES + l];
                e.i[l*NB +: NB] = m_i[row*LANES + l];
            end
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_r[k] = '0;
            m_i[k] = '0;
        end
        m_n     = 0;
        m_armed = 1'b0;
        m_err   = 1'b0;
        m_cnt   = 0;
    endtask

    // One clock of stimulus: drive after the sampling edge, update the model
    // at the active edge, queue the expected view for the monitor.
    task automatic step(input bit clr, input bit lv, input logic [NB-1:0] wr,
                        input logic [NB-1:0] wi, input bit start, input bit stage);
        @(negedge CLK);
        #1;
        RST        = 1'b1;
        CLR        = clr;
        LOAD_VALID = lv;
        LOAD_WR    = wr;
        LOAD_WI    = wi;
        START      = start;
        STAGE      = stage;
        @(posedge CLK);
        if (clr) begin
            m_armed = 1'b0;
            m_n     = 0;
            m_err   = 1'b0;
        end else if (!m_armed) begin
            if (lv) begin
                m_r[m_n] = wr;
                m_i[m_n] = wi;
                m_n++;
                if (m_n == N) begin
                    m_armed = 1'b1;
                    m_n     = 0;
                end
            end
        end else if (lv) begin
            m_err = 1'b1;
        end
        m_cnt = start ? 0 : (m_cnt + 1) % ROWS;
        sb_q.push_back(model_out());
    endtask

    task automatic idle(input bit start, input bit stage);
        step(1'b0, 1'b0, '0, '0, start, stage);
    endtask

    task automatic rnd_load(input bit lv, input bit start, input bit stage);
        step(1'b0, lv, NB'($urandom), NB'($urandom), start, stage);
    endtask

    // Reset mid-cycle; outputs must drop before any clock edge.
    task automatic do_reset();
        @(negedge CLK);
        #1;
        CLR        = 1'b0;
        LOAD_VALID = 1'b0;
        START      = 1'b0;
        RST        = 1'b0;
        #1;
        chk("async_rst_ready", 64'(LOAD_READY), 64'(1));
        chk("async_rst_tv",    64'(TABLE_VALID), 64'(0));
        chk("async_rst_err",   64'(LOAD_ERR), 64'(0));
        chk("async_rst_or",    64'(dut_or), 64'(0));
        chk("async_rst_oi",    64'(dut_oi), 64'(0));
        model_reset();
        @(posedge CLK);
        sb_q.push_back(model_out());
    endtask

    // Monitor: compare the DUT view against the queued expectation.
    always @(negedge CLK) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            chk("load_ready",  64'(LOAD_READY),  64'(mon_e.rdy));
            chk("table_valid", 64'(TABLE_VALID), 64'(mon_e.tv));
            chk("load_err",    64'(LOAD_ERR),    64'(mon_e.err));
            chk("or_row",      64'(dut_or),      64'(mon_e.r));
            chk("oi_row",      64'(dut_oi),      64'(mon_e.i));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        RST        = 1'b1;
        CLR        = 1'b0;
        LOAD_VALID = 1'b0;
        LOAD_WR    = '0;
        LOAD_WI    = '0;
        START      = 1'b0;
        STAGE      = 1'b0;
        model_reset();
        do_reset();

        // Streamed load: wr = k, wi = 31-k.
        for (int k = 0; k < N; k++) step(1'b0, 1'b1, NB'(k), NB'(N - 1 - k), 1'b0, 1'b0);
        idle(1'b1, 1'b0);
        repeat (16) idle(1'b0, 1'b0);
        idle(1'b1, 1'b1);
        repeat (16) idle(1'b0, 1'b1);

        // Offers while armed set the sticky error; CLR clears everything.
        repeat (3) rnd_load(1'b1, 1'b0, 1'b0);
        repeat (2) idle(1'b0, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);

        // Toggling LOAD_VALID: 32 accepted over 64 cycles.
        for (int i = 0; i < 2 * N; i++) rnd_load(i % 2 == 0, 1'b0, 1'($urandom % 2));
        repeat (10) idle(1'($urandom % 4 == 0), 1'($urandom % 2));

        // Mid-load CLR together with a pair, then a fresh load whose final
        // write coincides with START.
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        repeat (10) rnd_load(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, NB'($urandom), NB'($urandom), 1'b0, 1'b0);
        for (int k = 0; k < N; k++) rnd_load(1'b1, k == N - 1, 1'b0);
        repeat (10) idle(1'b0, 1'b0);

        // Mid-load asynchronous reset, then a new full load.
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        repeat (10) rnd_load(1'b1, 1'b0, 1'b0);
        do_reset();
        repeat (5) idle(1'($urandom % 2), 1'($urandom % 2));
        for (int k = 0; k < N; k++) rnd_load(1'b1, 1'b0, 1'b0);
        repeat (8) idle(1'b0, 1'b0);

        // START mid-sweep at count 5.
        idle(1'b1, 1'b0);
        repeat (5) idle(1'b0, 1'b0);
        idle(1'b1, 1'b0);
        repeat (3) idle(1'b0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            step(1'($urandom % 60 == 0), 1'($urandom % 2), NB'($urandom), NB'($urandom),
                 1'($urandom % 8 == 0), 1'($urandom % 2));

        @(negedge CLK);
        #1;
        chk("sb_drain", 64'(sb_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
